load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store request at a time from the
//  execute stage, drives the word-wide byte-addressed data memory (combinational read, write of
//  4 bytes at addr..addr+3 on posedge when memRW=1), and returns sign/zero-extended load data.
//  Sub-word stores (SB/SH) are done as read-merge-write, since the memory always writes 4 bytes.
// PARAMETERS
//  XLEN       32    data/address width
//  MEM_BYTES  4096  data memory size; byte addresses with addr+size > MEM_BYTES are range errors
//  CHECK_RNG  1     1: range errors reported, no access; 0: no range check (memory truncates addr)
// PORTS
//  clk         in   1     clock
//  rst_n       in   1     async active-low reset
//  req_valid   in   1     request present
//  req_ready   out  1     unit idle, request accepted when valid&ready
//  req_we      in   1     1 = store, 0 = load
//  req_funct3  in   3     RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr    in   XLEN  byte address
//  req_wdata   in   XLEN  store data (low byte/half used for SB/SH)
//  resp_valid  out  1     response present; held until resp_ready
//  resp_ready  in   1     consumer takes response
//  resp_rdata  out  XLEN  extended load data (0 for stores and errors)
//  resp_err    out  1     misaligned, unsupported funct3, or out of range
//  mem_addr    out  XLEN  to memory addrIn
//  mem_dataW   out  XLEN  to memory dataW
//  mem_dataR   in   XLEN  from memory dataR (combinational)
//  mem_memRW   out  1     to memory memRW (write strobe)
// BEHAVIOUR
//  - Reset (async): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0;
//    mem_memRW=0, mem_addr=0, mem_dataW=0. Reset mid-op aborts it; a write is committed only
//    if rst_n is high at the STORE-cycle edge. No response is produced for an aborted op.
//  - States: IDLE, READ, STORE, RESP.
//  - IDLE: req_ready=1. On accept, latch we/funct3/addr/wdata. Error check: LH/LHU/SH need
//    addr[0]=0; LW/SW need addr[1:0]=0; funct3 011/110/111 (and 100/101 for stores)
//    unsupported; range per CHECK_RNG. Error -> RESP with err=1, no memory access.
//    Else load or SB/SH -> READ; SW -> STORE.
//  - READ: mem_addr=latched addr, memRW=0. Sample mem_dataR at the edge.
//    Load: extract byte/half/word from sample bits [7:0]/[15:0]/[31:0], sign-extend
//    (LB/LH) or zero-extend (LBU/LHU) into resp_rdata; -> RESP.
//    SB/SH: merged = {sample[31:8], wdata[7:0]} or {sample[31:16], wdata[15:0]}; -> STORE.
//  - STORE: mem_addr=latched addr, mem_dataW=wdata (SW) or merged, mem_memRW=1 for exactly
//    this one cycle; -> RESP with rdata=0, err=0.
//  - RESP: resp_valid=1; outputs stable until resp_ready=1; then -> IDLE (req_ready rises the
//    next cycle; no accept in the handshake cycle).
//  - mem_memRW is 0 in every state except STORE; mem_addr/mem_dataW hold last values in IDLE/RESP.
//  - Latency accept->resp_valid: LW/LB/LH/LBU/LHU 2, SW 2, SB/SH 3, error 1 cycle.
//  - Request signals ignored when req_ready=0; no queueing.
// STRUCTURE
//  - Package lsu_pkg: funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010,
//    F3_BU=3'b100, F3_HU=3'b101), state enum lsu_state_t, size decode function.
//  - Sub-module lsu_align (combinational): extract+extend for loads and merge for SB/SH;
//    FSM, latches and error logic stay in load_store_unit.
// TESTING
//  - Memory model = word-wide, 4-byte little-endian write at addr, 4096 bytes.
//  - SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> memRW high 1 cycle; rdata 0xDEADBEEF, lat 2.
//  - After above, LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD.
//  - SB 0x011 wdata 0x12345655 over 0xDEADBEEF at 0x010 -> LW 0x010 = 0xDEAD55EF; SB lat 3;
//    bytes 0x014..0x016 unchanged.
//  - LW 0x002, SH 0x001, funct3 3'b011, LW 0xFFC with 0 preloaded OK; LW 0x1000 -> err=1,
//    rdata 0, memRW never high, latency 1.
//  - Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, new req ignored.
//  - Deassert rst_n during STORE of SW 0x020 0xA5A5A5A5 -> memRW drops at once, memory at
//    0x020 unchanged, resp_valid=0, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 encodings, FSM state type and decode helpers for
//           the load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_STORE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Access size in bytes; 0 marks an encoding with no defined size.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = 3'd1;
            F3_H, F3_HU: f3_size = 3'd2;
            F3_W:        f3_size = 3'd4;
            default:     f3_size = 3'd0;
        endcase
    endfunction

    function automatic logic f3_unsupported(input logic we, input logic [2:0] f3);
        if (we)
            f3_unsupported = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        else
            f3_unsupported = (f3_size(f3) == 3'd0);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3)
            F3_H, F3_HU: f3_misaligned = lsb[0];
            F3_W:        f3_misaligned = |lsb;
            default:     f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Combinational load extract/extend and sub-word store merge.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_sample,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load,
    output logic [XLEN-1:0] o_merged
);

    // The memory returns the addressed byte in lane 0, so no lane shifting is needed.
    always_comb begin
        o_load = '0;
        case (i_funct3)
            F3_B:    o_load = {{(XLEN-8){i_sample[7]}}, i_sample[7:0]};
            F3_H:    o_load = {{(XLEN-16){i_sample[15]}}, i_sample[15:0]};
            F3_W:    o_load = i_sample;
            F3_BU:   o_load = {{(XLEN-8){1'b0}}, i_sample[7:0]};
            F3_HU:   o_load = {{(XLEN-16){1'b0}}, i_sample[15:0]};
            default: o_load = '0;
        endcase
    end

    always_comb begin
        o_merged = i_wdata;
        case (i_funct3)
            F3_B:    o_merged = {i_sample[XLEN-1:8], i_wdata[7:0]};
            F3_H:    o_merged = {i_sample[XLEN-1:16], i_wdata[15:0]};
            default: o_merged = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Brief   : Single-outstanding load/store initiator for a word-wide,
//           byte-addressed data memory; sub-word stores use read-merge-write.
// Revision: 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 4096,
    parameter int CHECK_RNG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_dataW,
    input  logic [XLEN-1:0] mem_dataR,
    output logic            mem_memRW
);

    localparam logic [XLEN:0] C_MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    lsu_state_t      r_state;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_dataW;
    logic            r_mem_we;

    logic [2:0]      w_size;
    logic            w_unsup;
    logic            w_misal;
    logic            w_range_err;
    logic            w_req_err;
    logic            w_accept;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merged;

    assign w_size   = f3_size(req_funct3);
    assign w_unsup  = f3_unsupported(req_we, req_funct3);
    assign w_misal  = f3_misaligned(req_funct3, req_addr[1:0]);
    assign w_accept = req_valid && (r_state == ST_IDLE);

    generate
        if (CHECK_RNG != 0) begin : g_rng_chk
            logic [XLEN:0] w_end;
            assign w_end       = {1'b0, req_addr} + (XLEN+1)'(w_size);
            assign w_range_err = (w_end > C_MEM_LIMIT);
        end else begin : g_no_rng_chk
            assign w_range_err = 1'b0;
        end
    endgenerate

    assign w_req_err = w_unsup || w_misal || w_range_err;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_funct3 (r_funct3),
        .i_sample (mem_dataR),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // The write strobe is registered and cleared by default, so it is high for
    // exactly the STORE cycle and drops immediately on an asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dataW <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata;
                        if (w_req_err) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            r_mem_addr  <= req_addr;
                            r_mem_dataW <= req_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= ST_STORE;
                        end else begin
                            r_mem_addr <= req_addr;
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_we) begin
                        r_mem_dataW <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_state     <= ST_STORE;
                    end else begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end
                end
                ST_STORE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_addr   = r_mem_addr;
    assign mem_dataW  = r_mem_dataW;
    assign mem_memRW  = r_mem_we;

endmodule
`default_nettype wire
